// File: rtl/store_write_buffer_pkg.sv
// rtl/store_write_buffer_pkg.sv - shared datapath widths and drain FSM encoding
package store_write_buffer_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_e;
endpackage

// File: rtl/store_fwd_match.sv
// rtl/store_fwd_match.sv - youngest-match search of buffered stores for load forwarding
module store_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = store_write_buffer_pkg::ADDR_W,
  parameter int DATA_W = store_write_buffer_pkg::DATA_W
) (
  input  logic [ADDR_W-1:0]        ent_addr [DEPTH],
  input  logic [DATA_W-1:0]        ent_data [DEPTH],
  input  logic [DEPTH-1:0]         ent_valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end
endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order store buffer draining to data memory with load forwarding
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = store_write_buffer_pkg::ADDR_W,
  parameter int DATA_W = store_write_buffer_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  import store_write_buffer_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  drain_state_e      state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              push, pop;

  // A full buffer refuses stores even when the head is being popped this cycle.
  assign st_ready  = (count_q != CNT_W'(DEPTH));
  assign push      = st_valid && st_ready;
  assign pop       = (state_q == WRITE) && mem_ack;
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q[head_q];
  assign mem_wdata = data_q[head_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (push) begin
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE:  if (count_q != '0) state_d = WRITE;
      WRITE: if (pop && (count_d == '0)) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  store_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .ent_addr  (addr_q),
    .ent_data  (data_q),
    .ent_valid (valid_q),
    .head      (head_q),
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );
endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - scoreboard bench for store_write_buffer
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [AW-1:0] ld_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          empty;
  logic [2:0]    count;

  int errors = 0;
  int checks = 0;

  // Model: pend holds the buffered stores oldest-first, exp_q the writes memory should see.
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];
  bit          model_we;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .empty     (empty),
    .count     (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void fwd_model(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (pend[i]) begin
      if (pend[i][31:16] == a) begin
        hit = 1'b1;
        d   = pend[i][15:0];
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int old_n;
    bit acc;
    bit popm;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      model_we = 1'b0;
    end else begin
      old_n = pend.size();
      acc   = st_valid && (old_n < DEPTH);
      popm  = model_we && mem_ack;
      if (popm) void'(pend.pop_front());
      if (acc) begin
        pend.push_back({st_addr, st_data});
        exp_q.push_back({st_addr, st_data});
      end
      if (model_we) model_we = popm ? (pend.size() != 0) : 1'b1;
      else          model_we = (old_n != 0);
    end
  end

  always @(negedge clk) begin : monitor
    bit          h;
    logic [DW-1:0] d;
    logic [31:0] e;
    if (!rst) begin
      chk("count", count, pend.size());
      chk("empty", empty, pend.size() == 0);
      chk("st_ready", st_ready, pend.size() != DEPTH);
      chk("mem_we", mem_we, model_we);
      fwd_model(ld_addr, h, d);
      chk("fwd_hit", fwd_hit, h);
      chk("fwd_data", fwd_data, d);
      if (mem_we && pend.size() != 0) chk("head_entry", {mem_addr, mem_wdata}, pend[0]);
      if (mem_we && mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: got %0h expected none", {mem_addr, mem_wdata});
        end else begin
          e = exp_q.pop_front();
          chk("write_order", {mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    cyc();
    st_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(empty && !mem_we) && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_timeout", n < 200, 1);
  endtask

  task automatic wait_we();
    int n = 0;
    while (!mem_we && n < 50) begin
      cyc();
      n++;
    end
    chk("we_timeout", n < 50, 1);
  endtask

  initial begin
    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    mem_ack  = 1'b0;
    ld_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    rst = 1'b0;
    cyc();

    // Single store with ack held high
    mem_ack = 1'b1;
    push(16'h0010, 16'hBEEF);
    chk("single_we_c0", mem_we, 0);
    cyc();
    chk("single_we_c1", mem_we, 1);
    chk("single_addr", mem_addr, 16'h0010);
    chk("single_data", mem_wdata, 16'hBEEF);
    cyc();
    chk("single_count_c2", count, 0);
    chk("single_empty_c2", empty, 1);
    chk("single_we_c2", mem_we, 0);

    // Fill while memory stalls, then drain back-to-back
    mem_ack = 1'b0;
    wait_idle();
    for (int i = 1; i <= 4; i++) push(AW'(i), DW'(16'hA0 + i));
    chk("full_count", count, 4);
    chk("full_ready", st_ready, 0);
    st_valid = 1'b1;
    st_addr  = 16'h0005;
    st_data  = 16'h00A5;
    cyc();
    st_valid = 1'b0;
    chk("full_reject", count, 4);
    mem_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_addr", mem_addr, i);
      chk("drain_we", mem_we, 1);
      cyc();
    end
    chk("drain_empty", empty, 1);
    mem_ack = 1'b0;
    wait_idle();

    // Youngest-match forwarding
    push(16'h0020, 16'h1111);
    push(16'h0020, 16'h2222);
    ld_addr = 16'h0020;
    #1;
    chk("fwd_young_hit", fwd_hit, 1);
    chk("fwd_young_data", fwd_data, 16'h2222);
    ld_addr = 16'h0021;
    #1;
    chk("fwd_miss_hit", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    mem_ack = 1'b1;
    wait_idle();
    mem_ack = 1'b0;

    // Simultaneous push and pop across pointer wrap
    push(16'h0040, 16'h4000);
    push(16'h0041, 16'h4001);
    mem_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      st_valid = 1'b1;
      st_addr  = AW'(16'h0050 + k);
      st_data  = DW'(16'h5000 + k);
      cyc();
      chk("pushpop_count", count, 2);
    end
    st_valid = 1'b0;
    wait_idle();
    mem_ack = 1'b0;

    // Stall hold
    push(16'h0030, 16'h3030);
    wait_we();
    for (int k = 0; k < 5; k++) begin
      chk("hold_we", mem_we, 1);
      chk("hold_addr", mem_addr, 16'h0030);
      chk("hold_data", mem_wdata, 16'h3030);
      cyc();
    end
    mem_ack = 1'b1;
    wait_idle();
    mem_ack = 1'b0;

    // Reset in the middle of a write
    push(16'h0060, 16'h6000);
    push(16'h0061, 16'h6001);
    push(16'h0062, 16'h6002);
    wait_we();
    ld_addr = 16'h0060;
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_we", mem_we, 0);
    chk("mrst_count", count, 0);
    chk("mrst_fwd_hit", fwd_hit, 0);
    chk("mrst_empty", empty, 1);
    cyc();
    cyc();
    rst     = 1'b0;
    mem_ack = 1'b1;
    repeat (5) begin
      chk("mrst_no_write", mem_we, 0);
      cyc();
    end
    mem_ack = 1'b0;

    // Randomized traffic over a small address space so forwarding hits occur
    for (int k = 0; k < 400; k++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = AW'($urandom_range(0, 7));
      st_data  = DW'($urandom);
      ld_addr  = AW'($urandom_range(0, 7));
      mem_ack  = ($urandom_range(0, 3) != 0);
      cyc();
    end
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    wait_idle();
    chk("all_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
